// File: rtl/pipo_skid_reg.sv
// rtl/pipo_skid_reg.sv - PIPO pipeline register with valid/ready handshake and 2-entry skid buffer
//
// Holds up to two words between datapath stages so a stalled consumer never
// loses or duplicates data. Sustains one word per cycle when downstream is ready.
// in_ready and out_valid decode straight from the state flops, so there is no
// combinational path from out_ready to in_ready.
//
// Optional feature macro: PIPO_SKID_CNT_EN adds the CNT_W parameter and the
// xfer_cnt output (count of non-flushed output transfers, wraps, cleared by rst_n only).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous clear of all contents, highest priority
//   in_valid   in   1      upstream word valid
//   in_ready   out  1      block can accept a word
//   din        in   WIDTH  upstream data
//   out_valid  out  1      dout holds a valid word
//   out_ready  in   1      downstream accepts dout
//   dout       out  WIDTH  output data (registered)
//   xfer_cnt   out  CNT_W  output transfer count (PIPO_SKID_CNT_EN only)
//   occupancy  out  2      words held: 0, 1 or 2

module pipo_skid_reg #(
    parameter int WIDTH = 16
`ifdef PIPO_SKID_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
`ifdef PIPO_SKID_CNT_EN
    output logic [CNT_W-1:0] xfer_cnt,
`endif
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign dout      = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            S_EMPTY: occupancy = 2'd0;
            S_BUSY:  occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d = S_BUSY;
                    main_d  = din;
                end
            end
            S_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = din;
                end else if (in_fire) begin
                    // Consumer stalled: park the new word behind the one on dout.
                    state_d = S_FULL;
                    skid_d  = din;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d = S_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush discards everything, including this cycle's handshakes.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPO_SKID_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire && !flush) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipo_skid_reg.sv
// tb/tb_pipo_skid_reg.sv - scoreboard bench for pipo_skid_reg at WIDTH=16 and WIDTH=1

module tb_pipo_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] din;
    logic        din1;

    logic        in_ready, out_valid;
    logic [15:0] dout;
    logic [1:0]  occupancy;
    logic        in_ready1, out_valid1;
    logic        dout1;
    logic [1:0]  occupancy1;
`ifdef PIPO_SKID_CNT_EN
    logic [3:0]  xfer_cnt;
    logic [3:0]  xfer_cnt1;
    logic [3:0]  m_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          m_occ    = 0;
    int          n_acc    = 0;
    logic [15:0] exp_q[$];
    logic        exp1_q[$];

    always #5 clk = ~clk;

    pipo_skid_reg #(
        .WIDTH(16)
`ifdef PIPO_SKID_CNT_EN
        , .CNT_W(4)
`endif
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
`ifdef PIPO_SKID_CNT_EN
        .xfer_cnt(xfer_cnt),
`endif
        .occupancy(occupancy)
    );

    pipo_skid_reg #(
        .WIDTH(1)
`ifdef PIPO_SKID_CNT_EN
        , .CNT_W(4)
`endif
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .din(din1),
        .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1),
`ifdef PIPO_SKID_CNT_EN
        .xfer_cnt(xfer_cnt1),
`endif
        .occupancy(occupancy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of held words; capacity 2. Acceptance is decided
    // from the model's own fill level, never from the DUT.
    task automatic step();
        bit ofire, ifire;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            exp1_q.delete();
            m_occ = 0;
        end else begin
            ofire = (m_occ > 0) && out_ready;
            ifire = in_valid && (m_occ < 2);
            if (ofire) begin
                m_occ--;
`ifdef PIPO_SKID_CNT_EN
                m_cnt = m_cnt + 4'd1;
`endif
            end
            if (ifire) begin
                exp_q.push_back(din);
                exp1_q.push_back(din1);
                m_occ++;
                n_acc++;
            end
        end
        #1;
    endtask

    // Monitor: checks flags against the model and pops a word on every output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_occ != 0));
            check("in_ready", 32'(in_ready), 32'(m_occ != 2));
            check("occupancy", 32'(occupancy), 32'(m_occ));
            check("w1_occupancy", 32'(occupancy1), 32'(m_occ));
`ifdef PIPO_SKID_CNT_EN
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word16", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    check("dout16", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
            if (out_valid1 && out_ready && !flush) begin
                if (exp1_q.size() == 0) begin
                    check("unexpected_word1", 32'(dout1), 32'hFFFF_FFFF);
                end else begin
                    check("dout1", 32'(dout1), 32'(exp1_q.pop_front()));
                end
            end
        end
    end

    task automatic do_reset();
        #3;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_w1_out_valid", 32'(out_valid1), 32'd0);
        exp_q.delete();
        exp1_q.delete();
        m_occ = 0;
`ifdef PIPO_SKID_CNT_EN
        m_cnt = 4'd0;
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5 && m_occ != 0; i++) step();
        step();
        check("drain_left16", 32'(exp_q.size()), 32'd0);
        check("drain_left1", 32'(exp1_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        din1      = 1'b0;
`ifdef PIPO_SKID_CNT_EN
        m_cnt     = 4'd0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-transfer: load one word, then assert rst_n between edges.
        in_valid = 1'b1; din = 16'h5A5A; din1 = 1'b1; out_ready = 1'b0;
        step();
        do_reset();

        // Streaming 1..100 back-to-back.
        out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_valid = 1'b1;
            din      = 16'(i);
            din1     = i[0];
            step();
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        drain();

        // Stall, then ignore while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1; din = 16'h00AA; din1 = 1'b0;
        step();
        din = 16'h00BB; din1 = 1'b1;
        step();
        din = 16'hDEAD; din1 = 1'b0;
        step();
        check("stall_occupancy", 32'(occupancy), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_dout", 32'(dout), 32'h00AA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("unstall_dout", 32'(dout), 32'h00BB);
        step();
        check("unstall_out_valid", 32'(out_valid), 32'd0);

        // Flush while FULL with both handshakes requested.
        out_ready = 1'b0;
        in_valid  = 1'b1; din = 16'h0011; din1 = 1'b1;
        step();
        din = 16'h0022;
        step();
        flush = 1'b1; out_ready = 1'b1; din = 16'h0033;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_dout", 32'(dout), 32'd0);
        check("flush_w1_dout", 32'(dout1), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step();

`ifdef PIPO_SKID_CNT_EN
        // 17 transfers on a 4-bit counter wrap to 1; a flushed transfer does not count.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; din = 16'(i + 16'h100); din1 = i[0];
            step();
        end
        in_valid = 1'b0;
        step();
        check("cnt_wrap", 32'(xfer_cnt), 32'd1);
        in_valid = 1'b1; din = 16'h0777;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_flushed", 32'(xfer_cnt), 32'd1);
`endif

        // Random traffic: 1e4 accepted words with random valid/ready and rare flushes.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 499) == 0);
            din       = 16'($urandom);
            din1      = 1'($urandom);
            step();
            cyc++;
        end
        check("random_budget", 32'(n_acc >= 10000), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
